// File: rtl/spi_rx_deserializer.sv
// SPI mode-0 receive path: skips the command/address bits of each frame, captures the
// read-data bits MSB-first and hands the word to the consumer through a valid/ready register.
module spi_rx_deserializer #(
  parameter int SKIP_BITS = 10,
  parameter int DATAW     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             n_cs,
  input  logic             spi_clk,
  input  logic             miso,
  output logic [DATAW-1:0] data_out,
  output logic             valid_out,
  input  logic             ready_in,
  output logic             busy,
  output logic             overflow,
  output logic             frame_err
);

  localparam int MAXC = (SKIP_BITS > DATAW) ? SKIP_BITS : DATAW;
  localparam int CNTW = $clog2(MAXC + 1);
  localparam logic [CNTW-1:0] SKIP_LAST = CNTW'(SKIP_BITS - 1);
  localparam logic [CNTW-1:0] DATA_LAST = CNTW'(DATAW - 1);

  typedef enum logic [1:0] {IDLE, SKIP, DATA, DONE} state_t;

  state_t            state_reg, state_next;
  logic [CNTW-1:0]   cnt_reg, cnt_next;
  logic [DATAW-1:0]  shift_reg;
  logic [DATAW-1:0]  word;
  logic [DATAW-1:0]  data_reg;
  logic              valid_reg;
  logic              busy_reg, busy_next;
  logic              overflow_reg, overflow_next;
  logic              frame_err_reg, frame_err_next;
  logic              spi_clk_q_reg;
  logic              sclk_rise;
  logic              shift_en;
  logic              complete;
  logic              accept;
  logic              load;

  assign sclk_rise = spi_clk & ~spi_clk_q_reg & ~n_cs;

  // The completed word includes the bit being sampled this cycle.
  generate
    if (DATAW == 1) begin : g_word_1
      assign word = miso;
    end else begin : g_word_n
      assign word = {shift_reg[DATAW-2:0], miso};
    end
  endgenerate

  // State register (with its bit counter)
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Next-state logic; chip select deassertion overrides everything
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    if (n_cs) begin
      state_next = IDLE;
      cnt_next   = '0;
    end else begin
      case (state_reg)
        IDLE: begin
          state_next = (SKIP_BITS > 0) ? SKIP : DATA;
          cnt_next   = '0;
        end
        SKIP: begin
          if (sclk_rise) begin
            if (cnt_reg == SKIP_LAST) begin
              state_next = DATA;
              cnt_next   = '0;
            end else begin
              cnt_next = cnt_reg + 1'b1;
            end
          end
        end
        DATA: begin
          if (sclk_rise) begin
            if (cnt_reg == DATA_LAST) begin
              state_next = DONE;
              cnt_next   = '0;
            end else begin
              cnt_next = cnt_reg + 1'b1;
            end
          end
        end
        default: begin
          state_next = state_reg;
        end
      endcase
    end
  end

  // Output / datapath decode
  always_comb begin
    shift_en       = (state_reg == DATA) & sclk_rise;
    complete       = shift_en & (cnt_reg == DATA_LAST);
    accept         = valid_reg & ready_in;
    load           = complete & (~valid_reg | accept);
    overflow_next  = complete & valid_reg & ~ready_in;
    frame_err_next = n_cs & ((state_reg == SKIP) | (state_reg == DATA));
    busy_next      = (state_next == SKIP) | (state_next == DATA);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      spi_clk_q_reg <= 1'b0;
      shift_reg     <= '0;
      data_reg      <= '0;
      valid_reg     <= 1'b0;
      busy_reg      <= 1'b0;
      overflow_reg  <= 1'b0;
      frame_err_reg <= 1'b0;
    end else begin
      spi_clk_q_reg <= spi_clk;
      busy_reg      <= busy_next;
      overflow_reg  <= overflow_next;
      frame_err_reg <= frame_err_next;
      if (shift_en) begin
        shift_reg <= word;
      end
      // A dropped word leaves the holding register untouched.
      if (load) begin
        data_reg  <= word;
        valid_reg <= 1'b1;
      end else if (accept) begin
        valid_reg <= 1'b0;
      end
    end
  end

  assign data_out  = data_reg;
  assign valid_out = valid_reg;
  assign busy      = busy_reg;
  assign overflow  = overflow_reg;
  assign frame_err = frame_err_reg;

endmodule

// File: tb/tb_spi_rx_deserializer.sv
// Bench for spi_rx_deserializer: directed scenarios plus random frames, checked against a
// transaction-level model of the holding register and pulse counters.
module tb_spi_rx_deserializer;

  localparam int SKIP_BITS = 10;
  localparam int DATAW     = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             n_cs;
  logic             spi_clk;
  logic             miso;
  logic [DATAW-1:0] data_out;
  logic             valid_out;
  logic             ready_in;
  logic             busy;
  logic             overflow;
  logic             frame_err;

  int n_checks = 0;
  int n_fail   = 0;

  // transaction-level model
  logic [7:0] m_data  = 8'h00;
  logic       m_valid = 1'b0;
  int         exp_ovf  = 0;
  int         exp_ferr = 0;

  // pulse monitor
  int  ovf_cnt = 0;
  int  ferr_cnt = 0;
  int  wide_cnt = 0;
  logic ovf_prev = 1'b0;
  logic ferr_prev = 1'b0;

  spi_rx_deserializer #(.SKIP_BITS(SKIP_BITS), .DATAW(DATAW)) dut (
    .clk       (clk),
    .rst       (rst),
    .n_cs      (n_cs),
    .spi_clk   (spi_clk),
    .miso      (miso),
    .data_out  (data_out),
    .valid_out (valid_out),
    .ready_in  (ready_in),
    .busy      (busy),
    .overflow  (overflow),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (overflow)  ovf_cnt++;
    if (frame_err) ferr_cnt++;
    if ((overflow && ovf_prev) || (frame_err && ferr_prev)) wide_cnt++;
    ovf_prev  = overflow;
    ferr_prev = frame_err;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic send_bit(input logic b, input logic rdy);
    @(negedge clk);
    spi_clk = 1'b0;
    miso    = b;
    @(negedge clk);
    spi_clk = 1'b1;
    if (rdy) ready_in = 1'b1;
    @(negedge clk);
    ready_in = 1'b0;
  endtask

  task automatic start_frame();
    @(negedge clk);
    n_cs    = 1'b0;
    spi_clk = 1'b0;
    @(negedge clk);
  endtask

  task automatic end_frame();
    @(negedge clk);
    spi_clk = 1'b0;
    n_cs    = 1'b1;
    repeat (3) @(negedge clk);
    #1;
  endtask

  task automatic send_junk(input int n);
    for (int i = 0; i < n; i++) send_bit(1'($urandom_range(0, 1)), 1'b0);
  endtask

  // First n data bits of w, MSB first; rdy raises ready_in with the 8th edge
  task automatic send_data(input logic [7:0] w, input int n, input logic rdy);
    for (int i = 0; i < n; i++) send_bit(w[7-i], rdy && (i == 7));
  endtask

  task automatic model_complete(input logic [7:0] w);
    if (m_valid) exp_ovf++;
    else begin
      m_data  = w;
      m_valid = 1'b1;
    end
  endtask

  task automatic full_frame(input logic [7:0] w, input int extra);
    start_frame();
    send_junk(SKIP_BITS);
    send_data(w, 8, 1'b0);
    send_junk(extra);
    end_frame();
    model_complete(w);
    $display("frame   word=0x%02h extra=%0d", w, extra);
  endtask

  task automatic consume();
    @(negedge clk);
    check("consume_valid", 32'(valid_out), 32'(1'b1));
    check("consume_data", 32'(data_out), 32'(m_data));
    ready_in = 1'b1;
    @(negedge clk);
    ready_in = 1'b0;
    check("consume_clear", 32'(valid_out), 32'(1'b0));
    $display("accept  word=0x%02h", m_data);
    m_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; n_cs = 1'b1; spi_clk = 1'b0; miso = 1'b0; ready_in = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_data", 32'(data_out), 32'h0);
    check("rst_valid", 32'(valid_out), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_ovf", 32'(overflow), 32'h0);
    check("rst_ferr", 32'(frame_err), 32'h0);
    rst = 1'b0;

    // T1/T2: 0xA5 with latency check, then extra edges ignored
    start_frame();
    send_junk(SKIP_BITS);
    check("t1_busy", 32'(busy), 32'h1);
    send_data(8'hA5, 7, 1'b0);
    check("t1_pre_valid", 32'(valid_out), 32'h0);
    send_bit(1'b1, 1'b0);
    model_complete(8'hA5);
    check("t1_valid", 32'(valid_out), 32'h1);
    check("t1_data", 32'(data_out), 32'hA5);
    for (int i = 0; i < 6; i++) send_bit(i[0], 1'b0);
    end_frame();
    check("t2_data", 32'(data_out), 32'hA5);
    check("t2_ovf", 32'(ovf_cnt), 32'(exp_ovf));
    check("t2_busy", 32'(busy), 32'h0);
    repeat (5) @(negedge clk);
    check("t1_hold", 32'(valid_out), 32'h1);
    consume();

    // T3: overflow while holding 0x11
    full_frame(8'h11, 0);
    full_frame(8'h22, 0);
    check("t3_ovf_cnt", 32'(ovf_cnt), 32'(exp_ovf));
    check("t3_data", 32'(data_out), 32'h11);
    consume();

    // T4: accept in the same cycle as completion
    full_frame(8'h11, 0);
    start_frame();
    send_junk(SKIP_BITS);
    send_data(8'h22, 8, 1'b1);
    m_valid = 1'b0;
    model_complete(8'h22);
    check("t4_data", 32'(data_out), 32'h22);
    check("t4_valid", 32'(valid_out), 32'h1);
    end_frame();
    check("t4_ovf_cnt", 32'(ovf_cnt), 32'(exp_ovf));
    consume();

    // T5: aborted frame after 13 edges
    start_frame();
    send_junk(SKIP_BITS);
    send_data(8'hFF, 3, 1'b0);
    end_frame();
    exp_ferr++;
    check("t5_ferr_cnt", 32'(ferr_cnt), 32'(exp_ferr));
    check("t5_valid", 32'(valid_out), 32'h0);
    full_frame(8'h3C, 1);
    consume();

    // T6: reset mid-frame with an unconsumed word pending
    full_frame(8'h5A, 0);
    start_frame();
    send_junk(SKIP_BITS);
    send_data(8'hFF, 5, 1'b0);
    @(negedge clk);
    rst = 1'b1; n_cs = 1'b1; spi_clk = 1'b0;
    @(negedge clk);
    check("t6_data", 32'(data_out), 32'h0);
    check("t6_valid", 32'(valid_out), 32'h0);
    check("t6_busy", 32'(busy), 32'h0);
    check("t6_ovf", 32'(overflow), 32'h0);
    check("t6_ferr", 32'(frame_err), 32'h0);
    rst = 1'b0;
    m_valid = 1'b0;
    full_frame(8'hC3, 0);
    check("t6_ferr_cnt", 32'(ferr_cnt), 32'(exp_ferr));
    consume();

    // Random frames, aborts and consumption
    for (int it = 0; it < 24; it++) begin
      if ($urandom_range(0, 3) == 0) begin
        int k;
        k = $urandom_range(0, SKIP_BITS + 7);
        start_frame();
        send_junk(k);
        end_frame();
        exp_ferr++;
        $display("abort   edges=%0d", k);
      end else begin
        full_frame(8'($urandom), $urandom_range(0, 2));
      end
      check("rnd_valid", 32'(valid_out), 32'(m_valid));
      if (m_valid) check("rnd_data", 32'(data_out), 32'(m_data));
      if (m_valid && $urandom_range(0, 1) == 1) consume();
    end
    if (m_valid) consume();

    repeat (2) @(negedge clk);
    #1;
    check("final_ovf_cnt", 32'(ovf_cnt), 32'(exp_ovf));
    check("final_ferr_cnt", 32'(ferr_cnt), 32'(exp_ferr));
    check("pulse_width", 32'(wide_cnt), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
